// File: rtl/risc_load_run_ctrl_if.sv
// rtl/risc_load_run_ctrl_if.sv - host word stream (valid/ready) into the load/run sequencer
interface risc_load_run_ctrl_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/risc_load_run_ctrl.sv
// rtl/risc_load_run_ctrl.sv - host word-stream loader and run/halt sequencer for the RISC core
module risc_load_run_ctrl #(
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 4096,
    parameter logic        DONE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr_n,
    risc_load_run_ctrl_if.slave  host,
    output logic                 test_normal,
    output logic                 ext_instr_we,
    output logic [15:0]          ext_instr_addr,
    output logic [15:0]          ext_instr_data,
    output logic                 ext_data_we,
    output logic [15:0]          ext_data_addr,
    output logic [15:0]          ext_data_data,
    output logic                 cpu_clr,
    input  logic                 cpu_done,
    output logic                 busy,
    output logic                 run_done,
    output logic                 timeout,
    output logic [31:0]          cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CLR, S_RUN, S_DONE
    } state_e;

    // clr_cnt counts down from CLR_CYCLES-1 to 0 while in CLR
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_e          state_q, state_d;
    logic            s_ready_q, s_ready_d;
    logic            test_normal_q, test_normal_d;
    logic            cpu_clr_q, cpu_clr_d;
    logic            busy_q, busy_d;
    logic            run_done_q, run_done_d;
    logic            timeout_q, timeout_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic            instr_we_q, instr_we_d;
    logic [15:0]     instr_addr_q, instr_addr_d;
    logic [15:0]     instr_data_q, instr_data_d;
    logic            data_we_q, data_we_d;
    logic [15:0]     data_addr_q, data_addr_d;
    logic [15:0]     data_data_q, data_data_d;
    logic            target_q, target_d;
    logic [13:0]     rem_q, rem_d;
    logic [15:0]     ptr_q, ptr_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            accept;
    logic [15:0]     word;

    assign accept = host.s_valid & s_ready_q;
    assign word   = host.s_data;

    // Next-state and next-output logic; every output is a flop loaded from the next state
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        rem_d         = rem_q;
        ptr_d         = ptr_q;
        clr_cnt_d     = clr_cnt_q;
        run_done_d    = run_done_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        instr_we_d    = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_data_d  = instr_data_q;
        data_we_d     = 1'b0;
        data_addr_d   = data_addr_q;
        data_data_d   = data_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (word[14]) begin
                        state_d       = S_CLR;
                        clr_cnt_d     = CW'(CLR_CYCLES - 1);
                        run_done_d    = 1'b0;
                        timeout_d     = 1'b0;
                        cycle_count_d = 32'd0;
                    end else if (word[13:0] == 14'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_ADDR;
                        target_d = word[15];
                        rem_d    = word[13:0];
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    ptr_d   = word;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (target_q) begin
                        data_we_d   = 1'b1;
                        data_addr_d = ptr_q;
                        data_data_d = word;
                    end else begin
                        instr_we_d   = 1'b1;
                        instr_addr_d = ptr_q;
                        instr_data_d = word;
                    end
                    ptr_d = ptr_q + 16'd1;
                    rem_d = rem_q - 14'd1;
                    if (rem_q == 14'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLR: begin
                if (clr_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                // cycle_count is still 0 in the first RUN cycle, when the core's flag is stale
                if (cycle_count_q != 32'd0 && cpu_done == DONE_LEVEL) begin
                    run_done_d = 1'b1;
                    state_d    = S_DONE;
                end else if (MAX_CYCLES != 0 && cycle_count_q == 32'(MAX_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        s_ready_d     = state_d inside {S_IDLE, S_ADDR, S_DATA, S_DONE};
        test_normal_d = state_d inside {S_IDLE, S_ADDR, S_DATA};
        cpu_clr_d     = !(state_d inside {S_RUN, S_DONE});
        busy_d        = !(state_d inside {S_IDLE, S_DONE});
    end

    // State and registered outputs; reset puts the core in clear with memories on the ext ports
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= S_IDLE;
            s_ready_q     <= 1'b0;
            test_normal_q <= 1'b1;
            cpu_clr_q     <= 1'b1;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= 32'd0;
            instr_we_q    <= 1'b0;
            instr_addr_q  <= 16'd0;
            instr_data_q  <= 16'd0;
            data_we_q     <= 1'b0;
            data_addr_q   <= 16'd0;
            data_data_q   <= 16'd0;
            target_q      <= 1'b0;
            rem_q         <= 14'd0;
            ptr_q         <= 16'd0;
            clr_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            test_normal_q <= test_normal_d;
            cpu_clr_q     <= cpu_clr_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            instr_we_q    <= instr_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_data_q  <= instr_data_d;
            data_we_q     <= data_we_d;
            data_addr_q   <= data_addr_d;
            data_data_q   <= data_data_d;
            target_q      <= target_d;
            rem_q         <= rem_d;
            ptr_q         <= ptr_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    assign host.s_ready   = s_ready_q;
    assign test_normal    = test_normal_q;
    assign cpu_clr        = cpu_clr_q;
    assign busy           = busy_q;
    assign run_done       = run_done_q;
    assign timeout        = timeout_q;
    assign cycle_count    = cycle_count_q;
    assign ext_instr_we   = instr_we_q;
    assign ext_instr_addr = instr_addr_q;
    assign ext_instr_data = instr_data_q;
    assign ext_data_we    = data_we_q;
    assign ext_data_addr  = data_addr_q;
    assign ext_data_data  = data_data_q;

endmodule
